// File: rtl/izh_pkg.sv
// Izhikevich neuron constants, fixed-point widths and scheduler FSM encodings.
// No logic of its own; imported by izh_update and izh_scheduler.
// Values are Q8.7 signed (FRAC fractional bits) unless noted.
package izh_pkg;

  localparam int V_W   = 16;  // width of stored v and u
  localparam int CUR_W = 8;   // width of per-neuron input current
  localparam int FRAC  = 7;   // fractional bits of the fixed-point format

  // Model coefficients, already scaled to the fixed-point format
  localparam int A      = 24;
  localparam int B      = 100;
  localparam int C      = -48;   // reset potential, 16'hFFD0
  localparam int D      = 1024;
  localparam int THRESH = 208;

  // Scheduler FSM encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Clamp a 32-bit signed intermediate into the 16-bit state range
  function automatic logic signed [V_W-1:0] sat16(input logic signed [31:0] x);
    if (x > 32'sd32767) begin
      return 16'sh7FFF;
    end else if (x < -32'sd32768) begin
      return 16'sh8000;
    end else begin
      return x[V_W-1:0];
    end
  endfunction

endpackage

// File: rtl/izh_update.sv
// One Izhikevich neuron update step: (v, u, I) -> (v', u', spike).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to commit the result.
module izh_update
  import izh_pkg::*;
(
  input  logic [V_W-1:0]   v,
  input  logic [V_W-1:0]   u,
  input  logic [CUR_W-1:0] cur,
  output logic [V_W-1:0]   v_nxt,
  output logic [V_W-1:0]   u_nxt,
  output logic             spk
);

  logic signed [31:0] v32;
  logic signed [31:0] u32;
  logic signed [31:0] i32;
  logic signed [31:0] sq_term;
  logic signed [31:0] lin_term;
  logic signed [31:0] dv_sum;
  logic signed [31:0] recov;

  // Sign-extend the state into 32-bit intermediates and evaluate both branches
  always_comb begin
    v32      = {{(32-V_W){v[V_W-1]}}, v};
    u32      = {{(32-V_W){u[V_W-1]}}, u};
    i32      = {{(32-CUR_W){1'b0}}, cur};
    sq_term  = (32'sd2 * v32 * v32) >>> FRAC;
    lin_term = (32'sd5 * v32) >>> FRAC;
    dv_sum   = sq_term + lin_term - u32 + i32;
    recov    = (A * (B * v32 - u32)) >>> FRAC;
    spk      = (v32 >= THRESH);
    if (spk) begin
      v_nxt = V_W'(C);
      u_nxt = sat16(u32 + D);
    end else begin
      v_nxt = sat16(dv_sum);
      u_nxt = sat16(u32 + recov);
    end
  end

endmodule

// File: rtl/izh_scheduler.sv
// Sweeps one shared izh_update datapath over N_NEURONS states, one neuron per cycle per tick.
// Latency: tick at edge k writes neuron i at edge k+1+i; sweep_done follows in the next cycle.
// Backpressure: spike events held until spk_ready; one queued tick, extra ticks/merges flag overrun.
module izh_scheduler
  import izh_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int IDX_W     = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 cur_wr_en,
  input  logic [IDX_W-1:0]     cur_wr_addr,
  input  logic [7:0]           cur_wr_data,
  input  logic [IDX_W-1:0]     rd_addr,
  output logic [15:0]          rd_v,
  output logic                 busy,
  output logic                 sweep_done,
  output logic [N_NEURONS-1:0] spike_vec,
  output logic                 spk_valid,
  output logic [IDX_W-1:0]     spk_id,
  input  logic                 spk_ready,
  output logic                 overrun
);

  logic [V_W-1:0]       v_mem   [N_NEURONS];
  logic [V_W-1:0]       u_mem   [N_NEURONS];
  logic [CUR_W-1:0]     cur_mem [N_NEURONS];

  logic [1:0]           state;
  logic [IDX_W-1:0]     idx;
  logic                 tick_pend;
  logic [N_NEURONS-1:0] shadow;
  logic [N_NEURONS-1:0] pend;
  logic                 hold;
  logic [IDX_W-1:0]     hold_id;

  logic                 sweeping;
  logic                 in_done;
  logic                 last_idx;
  logic                 accept;
  logic [IDX_W-1:0]     low_id;
  logic [N_NEURONS-1:0] clr_mask;
  logic [V_W-1:0]       v_nxt;
  logic [V_W-1:0]       u_nxt;
  logic                 spk;

  izh_update u_update (
    .v     (v_mem[idx]),
    .u     (u_mem[idx]),
    .cur   (cur_mem[idx]),
    .v_nxt (v_nxt),
    .u_nxt (u_nxt),
    .spk   (spk)
  );

  assign sweeping   = (state == ST_SWEEP);
  assign in_done    = (state == ST_DONE);
  assign last_idx   = (idx == IDX_W'(N_NEURONS - 1));
  assign busy       = (state != ST_IDLE);
  assign sweep_done = in_done;
  assign rd_v       = v_mem[rd_addr];
  assign spk_valid  = |pend;
  // A presented event is frozen until taken, even if a lower bit arrives meanwhile
  assign spk_id     = hold ? hold_id : low_id;
  assign accept     = spk_valid & spk_ready;

  // Lowest pending neuron index and the bit cleared by an accepted event
  always_comb begin
    low_id   = '0;
    clr_mask = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (pend[i]) low_id = IDX_W'(i);
    end
    if (accept) clr_mask[spk_id] = 1'b1;
  end

  // Sweep sequencing: idle until tick, one neuron per cycle, one DONE cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state <= ST_SWEEP;
            idx   <= '0;
          end
        end
        ST_SWEEP: begin
          idx <= idx + 1'b1;
          if (last_idx) state <= ST_DONE;
        end
        ST_DONE: begin
          // A queued tick (or one arriving now) restarts with no idle gap
          if (tick_pend || tick) begin
            state <= ST_SWEEP;
            idx   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // One-deep tick queue while busy; consumed on the DONE cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_pend <= 1'b0;
    end else if (in_done) begin
      tick_pend <= 1'b0;
    end else if (busy && tick) begin
      tick_pend <= 1'b1;
    end
  end

  // Sticky overrun: dropped tick, or a new spike landing on an unconsumed one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if ((busy && tick && tick_pend) ||
                 (in_done && |(pend & ~clr_mask & shadow))) begin
      overrun <= 1'b1;
    end
  end

  // Neuron state file: commit the datapath result for the neuron under update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_mem[i] <= '0;
        u_mem[i] <= '0;
      end
    end else if (sweeping) begin
      v_mem[idx] <= v_nxt;
      u_mem[idx] <= u_nxt;
    end
  end

  // Current file: host writes in any state, read by the datapath next cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_NEURONS; i++) cur_mem[i] <= '0;
    end else if (cur_wr_en) begin
      cur_mem[cur_wr_addr] <= cur_wr_data;
    end
  end

  // Per-sweep spike capture, published and merged into pending on DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow    <= '0;
      spike_vec <= '0;
      pend      <= '0;
    end else begin
      if (sweeping) shadow[idx] <= spk;
      if (in_done) begin
        spike_vec <= shadow;
        shadow    <= '0;
      end
      pend <= (pend & ~clr_mask) | (in_done ? shadow : '0);
    end
  end

  // Remember the presented event while the consumer stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold    <= 1'b0;
      hold_id <= '0;
    end else begin
      hold    <= spk_valid & ~spk_ready;
      hold_id <= spk_id;
    end
  end

endmodule
